// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way cache: line geometry defaults, PLRU
// history bit positions (also used by the front end's history update),
// the miss-handler state encoding and a one-hot to way-index helper.
package cache_pkg;

    localparam int BLKIDX_BIT_DEF = 4;
    localparam int WRDIDX_BIT_DEF = 4;
    localparam int WORDS_PER_LINE = 1 << WRDIDX_BIT_DEF;
    localparam int NUM_WAYS       = 4;

    // PLRU tree: root chooses the half, the two leaves choose within a half.
    // Root = 0 evicts from ways 2/3 (PLRU_HI decides), root = 1 evicts from
    // ways 0/1 (PLRU_LO decides).
    localparam int PLRU_ROOT = 0;
    localparam int PLRU_LO   = 1;
    localparam int PLRU_HI   = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_RD,
        S_WB_WR,
        S_RF_REQ,
        S_RF_WAIT,
        S_META,
        S_UC_REQ,
        S_UC_WAIT,
        S_FIN
    } mh_state_e;

    function automatic logic [1:0] onehot_to_way(input logic [NUM_WAYS-1:0] oh);
        logic [1:0] way;
        way = 2'd0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (oh[i]) way = 2'(i);
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_plru_victim.sv
// Victim selection for a 4-way set, purely combinational.
// Ports:
//   valid   - valid bits of the set
//   history - 3-bit PLRU tree of the set
//   victim  - one-hot way to evict: lowest invalid way, else the PLRU choice
module cache_plru_victim
    import cache_pkg::*;
(
    input  logic [3:0] valid,
    input  logic [2:0] history,
    output logic [3:0] victim
);

    always_comb begin
        victim = 4'b0000;
        if      (!valid[0]) victim = 4'b0001;
        else if (!valid[1]) victim = 4'b0010;
        else if (!valid[2]) victim = 4'b0100;
        else if (!valid[3]) victim = 4'b1000;
        else if (!history[PLRU_ROOT]) victim = history[PLRU_HI] ? 4'b0100 : 4'b1000;
        else                          victim = history[PLRU_LO] ? 4'b0001 : 4'b0010;
    end

endmodule

// File: rtl/cache4way_miss_handler.sv
// Refill / write-back engine of the 4-way cache.
// Cached miss: choose victim, write it back if dirty, refill the line word by
// word, write tag/valid/dirty, then pulse handler_fin. Uncached: one word
// read or write on the memory bus.
// Ports:
//   handler_*  - request interface from the cache front end
//   mh_*       - cache array access (data 1-cycle sync read, metadata comb)
//   mem_*      - memory bus, request/accept handshake then data/complete,
//                at most one transaction outstanding
module cache4way_miss_handler
    import cache_pkg::*;
#(
    parameter int BLKIDX_BIT = BLKIDX_BIT_DEF,
    parameter int WRDIDX_BIT = WRDIDX_BIT_DEF,
    parameter int TAG_BIT    = 32 - 2 - WRDIDX_BIT - BLKIDX_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  handler_req,
    input  logic                  handler_cached,
    input  logic [31:0]           handler_paddr,
    input  logic [BLKIDX_BIT-1:0] handler_blkidx,
    input  logic [31:0]           handler_wdata,
    input  logic [3:0]            handler_wen,
    output logic                  handler_fin,
    output logic [31:0]           handler_rdata,
    output logic [BLKIDX_BIT-1:0] mh_blkidx,
    output logic [WRDIDX_BIT-1:0] mh_wrdidx,
    output logic [31:0]           mh_wdata,
    output logic [15:0]           mh_wen,
    input  logic [127:0]          mh_rdata,
    input  logic [4*TAG_BIT-1:0]  mh_tag_r,
    input  logic [3:0]            mh_valid_r,
    input  logic [3:0]            mh_dirty_r,
    input  logic [2:0]            mh_history_r,
    output logic [3:0]            mh_meta_wen,
    output logic [TAG_BIT-1:0]    mh_tag_w,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [31:0]           mem_rdata
);

    mh_state_e state, state_nxt;

    logic [31:2]           paddr_q;
    logic [BLKIDX_BIT-1:0] blkidx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wen_q;
    logic [WRDIDX_BIT-1:0] k_q;
    logic [1:0]            victim_q;
    logic [TAG_BIT-1:0]    victim_tag_q;
    logic                  addr_done_q;   // write-back word accepted, awaiting completion
    logic                  wb_cap_q;      // write-back word already captured from the array
    logic [31:0]           wb_data_q;
    logic [31:0]           rdata_q;

    logic [3:0]            victim_oh;
    logic [1:0]            victim_idx;
    logic [TAG_BIT-1:0]    lookup_tag;
    logic [31:0]           victim_word;
    logic                  last_word;
    logic                  wb_beat_done;
    logic                  rf_beat;
    logic                  uc_done;
    logic                  unused_addr_lsb;

    // Byte offset bits are never used; the bus always gets word addresses.
    assign unused_addr_lsb = ^handler_paddr[1:0];

    cache_plru_victim u_victim (
        .valid   (mh_valid_r),
        .history (mh_history_r),
        .victim  (victim_oh)
    );

    assign victim_idx = onehot_to_way(victim_oh);

    always_comb begin
        lookup_tag  = mh_tag_r[TAG_BIT-1:0];
        victim_word = mh_rdata[31:0];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (victim_idx == 2'(w)) lookup_tag  = mh_tag_r[w*TAG_BIT +: TAG_BIT];
            if (victim_q   == 2'(w)) victim_word = mh_rdata[w*32 +: 32];
        end
    end

    assign last_word     = (k_q == '1);
    // A beat completes when data_ok arrives after (or together with) addr_ok.
    assign wb_beat_done  = (state == S_WB_WR) && mem_data_ok && (addr_done_q || mem_addr_ok);
    assign rf_beat       = ((state == S_RF_REQ) && mem_addr_ok && mem_data_ok) ||
                           ((state == S_RF_WAIT) && mem_data_ok);
    assign uc_done       = ((state == S_UC_REQ) && mem_addr_ok && mem_data_ok) ||
                           ((state == S_UC_WAIT) && mem_data_ok);

    assign handler_rdata = rdata_q;
    assign mh_blkidx     = blkidx_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values of the previous cycle, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            paddr_q      <= '0;
            blkidx_q     <= '0;
            wdata_q      <= '0;
            wen_q        <= '0;
            k_q          <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            addr_done_q  <= 1'b0;
            wb_cap_q     <= 1'b0;
            wb_data_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && handler_req) begin
                paddr_q  <= handler_paddr[31:2];
                blkidx_q <= handler_blkidx;
                wdata_q  <= handler_wdata;
                wen_q    <= handler_wen;
            end

            if (state == S_LOOKUP) begin
                victim_q     <= victim_idx;
                victim_tag_q <= lookup_tag;
            end

            if (state == S_LOOKUP)              k_q <= '0;
            else if (wb_beat_done || rf_beat)   k_q <= k_q + 1'b1;

            // The array word read in WB_RD is only on mh_rdata during the first
            // WB_WR cycle; hold it for the rest of the bus handshake.
            if (state == S_WB_WR) begin
                if (wb_beat_done) begin
                    wb_cap_q    <= 1'b0;
                    addr_done_q <= 1'b0;
                end else begin
                    if (!wb_cap_q) begin
                        wb_cap_q  <= 1'b1;
                        wb_data_q <= victim_word;
                    end
                    if (mem_addr_ok) addr_done_q <= 1'b1;
                end
            end

            if (uc_done && wen_q == 4'b0000) rdata_q <= mem_rdata;
        end
    end

    // NOTE: every output and next-state signal gets a default before the case
    // so no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_nxt   = state;
        handler_fin = 1'b0;
        mh_wrdidx   = '0;
        mh_wdata    = '0;
        mh_wen      = '0;
        mh_meta_wen = '0;
        mh_tag_w    = '0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_wstrb   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state)
            S_IDLE: begin
                handler_fin = !handler_req;
                if (handler_req) state_nxt = handler_cached ? S_LOOKUP : S_UC_REQ;
            end
            S_LOOKUP: begin
                state_nxt = (mh_valid_r[victim_idx] && mh_dirty_r[victim_idx]) ? S_WB_RD : S_RF_REQ;
            end
            S_WB_RD: begin
                mh_wrdidx = k_q;
                state_nxt = S_WB_WR;
            end
            S_WB_WR: begin
                mem_req   = !addr_done_q;
                mem_wr    = 1'b1;
                mem_wstrb = 4'hF;
                mem_addr  = {victim_tag_q, paddr_q[31-TAG_BIT:WRDIDX_BIT+2], k_q, 2'b00};
                mem_wdata = wb_cap_q ? wb_data_q : victim_word;
                if (wb_beat_done) state_nxt = last_word ? S_RF_REQ : S_WB_RD;
            end
            S_RF_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {paddr_q[31:WRDIDX_BIT+2], k_q, 2'b00};
                if (mem_addr_ok) state_nxt = mem_data_ok ? (last_word ? S_META : S_RF_REQ) : S_RF_WAIT;
            end
            S_RF_WAIT: begin
                if (mem_data_ok) state_nxt = last_word ? S_META : S_RF_REQ;
            end
            S_META: begin
                mh_meta_wen = 4'b0001 << victim_q;
                mh_tag_w    = paddr_q[31:32-TAG_BIT];
                state_nxt   = S_FIN;
            end
            S_UC_REQ: begin
                mem_req   = 1'b1;
                mem_wr    = |wen_q;
                mem_wstrb = wen_q;
                mem_addr  = {paddr_q[31:2], 2'b00};
                mem_wdata = wdata_q;
                if (mem_addr_ok) state_nxt = mem_data_ok ? S_FIN : S_UC_WAIT;
            end
            S_UC_WAIT: begin
                if (mem_data_ok) state_nxt = S_FIN;
            end
            S_FIN: begin
                handler_fin = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Refill word goes to the victim way in the same cycle its data arrives.
        if (rf_beat) begin
            mh_wrdidx = k_q;
            mh_wdata  = mem_rdata;
            mh_wen    = 16'h000F << {victim_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_cache4way_miss_handler.sv
// Scoreboard bench for cache4way_miss_handler: the driver computes every
// expected bus transaction, array write, metadata write and finish value from
// a line-level reference model and queues it; a monitor pops and compares
// whenever the DUT presents the corresponding output.
module tb_cache4way_miss_handler;

    localparam int BLKIDX_BIT = 4;
    localparam int WRDIDX_BIT = 4;
    localparam int TAG_BIT    = 22;
    localparam int WPL        = 16;

    logic                  clk;
    logic                  rst;
    logic                  handler_req;
    logic                  handler_cached;
    logic [31:0]           handler_paddr;
    logic [BLKIDX_BIT-1:0] handler_blkidx;
    logic [31:0]           handler_wdata;
    logic [3:0]            handler_wen;
    logic                  handler_fin;
    logic [31:0]           handler_rdata;
    logic [BLKIDX_BIT-1:0] mh_blkidx;
    logic [WRDIDX_BIT-1:0] mh_wrdidx;
    logic [31:0]           mh_wdata;
    logic [15:0]           mh_wen;
    logic [127:0]          mh_rdata;
    logic [4*TAG_BIT-1:0]  mh_tag_r;
    logic [3:0]            mh_valid_r;
    logic [3:0]            mh_dirty_r;
    logic [2:0]            mh_history_r;
    logic [3:0]            mh_meta_wen;
    logic [TAG_BIT-1:0]    mh_tag_w;
    logic                  mem_req;
    logic                  mem_wr;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [31:0]           mem_rdata;

    cache4way_miss_handler dut (
        .clk(clk), .rst(rst),
        .handler_req(handler_req), .handler_cached(handler_cached),
        .handler_paddr(handler_paddr), .handler_blkidx(handler_blkidx),
        .handler_wdata(handler_wdata), .handler_wen(handler_wen),
        .handler_fin(handler_fin), .handler_rdata(handler_rdata),
        .mh_blkidx(mh_blkidx), .mh_wrdidx(mh_wrdidx), .mh_wdata(mh_wdata),
        .mh_wen(mh_wen), .mh_rdata(mh_rdata), .mh_tag_r(mh_tag_r),
        .mh_valid_r(mh_valid_r), .mh_dirty_r(mh_dirty_r),
        .mh_history_r(mh_history_r), .mh_meta_wen(mh_meta_wen),
        .mh_tag_w(mh_tag_w), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- cache set model (one set presented to the DUT) -------
    logic [31:0]        cdata [4][WPL];
    logic [TAG_BIT-1:0] ctag  [4];
    logic [3:0]         cvalid;
    logic [3:0]         cdirty;
    logic [2:0]         chist;

    assign mh_tag_r     = {ctag[3], ctag[2], ctag[1], ctag[0]};
    assign mh_valid_r   = cvalid;
    assign mh_dirty_r   = cdirty;
    assign mh_history_r = chist;

    always @(posedge clk)
        mh_rdata <= {cdata[3][mh_wrdidx], cdata[2][mh_wrdidx], cdata[1][mh_wrdidx], cdata[0][mh_wrdidx]};

    // ---------------- memory contents ---------------------------------------
    logic [31:0] mem_over [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- scoreboard ---------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] data;
    } mem_ev_t;

    typedef struct packed {
        logic [15:0] wen;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [3:0]  blk;
    } arr_ev_t;

    typedef struct packed {
        logic [3:0]         wen;
        logic [TAG_BIT-1:0] tag;
        logic [3:0]         blk;
    } meta_ev_t;

    mem_ev_t     mem_q  [$];
    arr_ev_t     arr_q  [$];
    meta_ev_t    meta_q [$];
    logic [31:0] fin_q  [$];

    int          checks    = 0;
    int          errors    = 0;
    int          arr_count = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got event %0h, expected none (t=%0t)", name, act, $time);
    endtask

    // ---------------- memory responder ---------------------------------------
    // 0: random accept/latency, 1: fixed latency, 2: zero-wait, 3: addr+data same cycle
    int          rsp_mode = 0;
    int          rsp_lat  = 1;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data;

    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = $urandom;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = pend_data;
                    pend        = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (mem_req && (rsp_mode != 0 || $urandom_range(0, 1) == 0)) begin
                mem_addr_ok = 1'b1;
                pend_data   = mem_wr ? $urandom : mem_val(mem_addr);
                if (rsp_mode == 3) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = pend_data;
                end else begin
                    pend     = 1'b1;
                    pend_cnt = (rsp_mode == 0) ? $urandom_range(0, 3) :
                               (rsp_mode == 1) ? rsp_lat - 1 : 0;
                end
            end
        end
    end

    // ---------------- monitor -------------------------------------------------
    initial begin
        mem_ev_t  me;
        arr_ev_t  ae;
        meta_ev_t te;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req && mem_addr_ok) begin
                    if (mem_q.size() == 0) unexpected("mem_req", {32'h0, mem_addr});
                    else begin
                        me = mem_q.pop_front();
                        check("mem_addr", mem_addr, me.addr);
                        check("mem_wr", mem_wr, me.wr);
                        check("mem_wstrb", mem_wstrb, me.strb);
                        if (me.wr) check("mem_wdata", mem_wdata, me.data);
                    end
                end
                if (mh_wen != 16'h0) begin
                    arr_count++;
                    if (arr_q.size() == 0) unexpected("mh_wen", {48'h0, mh_wen});
                    else begin
                        ae = arr_q.pop_front();
                        check("mh_wen", mh_wen, ae.wen);
                        check("mh_wrdidx", mh_wrdidx, ae.idx);
                        check("mh_wdata", mh_wdata, ae.data);
                        check("mh_blkidx_data", mh_blkidx, ae.blk);
                    end
                end
                if (mh_meta_wen != 4'h0) begin
                    if (meta_q.size() == 0) unexpected("mh_meta_wen", {60'h0, mh_meta_wen});
                    else begin
                        te = meta_q.pop_front();
                        check("mh_meta_wen", mh_meta_wen, te.wen);
                        check("mh_tag_w", mh_tag_w, te.tag);
                        check("mh_blkidx_meta", mh_blkidx, te.blk);
                    end
                end
                if (handler_fin && handler_req) begin
                    if (fin_q.size() == 0) unexpected("handler_fin", {32'h0, handler_rdata});
                    else check("handler_rdata", handler_rdata, fin_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver and reference model ------------------------------
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic start_txn(input bit cached, input logic [31:0] paddr, input logic [3:0] blk,
                             input logic [31:0] wdata, input logic [3:0] wen);
        int          v;
        logic [31:0] a;
        if (cached) begin
            v = -1;
            for (int w = 0; w < 4; w++) if (!cvalid[w] && v < 0) v = w;
            if (v < 0) begin
                if (!chist[0]) v = chist[2] ? 2 : 3;
                else           v = chist[1] ? 0 : 1;
            end
            if (cvalid[v] && cdirty[v]) begin
                for (int k = 0; k < WPL; k++) begin
                    a = (32'(ctag[v]) << 10) | (paddr & 32'h0000_03C0) | 32'(k * 4);
                    mem_q.push_back('{addr: a, wr: 1'b1, strb: 4'hF, data: cdata[v][k]});
                end
            end
            for (int k = 0; k < WPL; k++) begin
                a = (paddr & 32'hFFFF_FFC0) | 32'(k * 4);
                mem_q.push_back('{addr: a, wr: 1'b0, strb: 4'h0, data: 32'h0});
                arr_q.push_back('{wen: 16'(16'h000F << (4 * v)), idx: 4'(k), data: mem_val(a), blk: blk});
            end
            meta_q.push_back('{wen: 4'(4'b0001 << v), tag: TAG_BIT'(paddr >> 10), blk: blk});
        end else begin
            a = paddr & 32'hFFFF_FFFC;
            mem_q.push_back('{addr: a, wr: (wen != 4'h0), strb: wen, data: wdata});
            if (wen == 4'h0) last_rdata = mem_val(a);
        end
        fin_q.push_back(last_rdata);
        handler_cached = cached;
        handler_paddr  = paddr;
        handler_blkidx = blk;
        handler_wdata  = wdata;
        handler_wen    = wen;
        handler_req    = 1'b1;
    endtask

    task automatic finish_txn(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            step();
            if (handler_fin) done = 1'b1;
        end
        handler_req = 1'b0;
        check({name, "_fin_seen"}, done, 1'b1);
        check({name, "_mem_left"}, mem_q.size(), 0);
        check({name, "_arr_left"}, arr_q.size(), 0);
        check({name, "_meta_left"}, meta_q.size(), 0);
        check({name, "_fin_left"}, fin_q.size(), 0);
        mem_q.delete(); arr_q.delete(); meta_q.delete(); fin_q.delete();
        step();
        check({name, "_idle_fin"}, handler_fin, 1'b1);
    endtask

    task automatic run_txn(input string name, input bit cached, input logic [31:0] paddr,
                           input logic [3:0] blk, input logic [31:0] wdata, input logic [3:0] wen);
        start_txn(cached, paddr, blk, wdata, wen);
        finish_txn(name);
    endtask

    task automatic fill_set(input logic [3:0] valid, input logic [3:0] dirty, input logic [2:0] hist);
        cvalid = valid;
        cdirty = dirty;
        chist  = hist;
        for (int w = 0; w < 4; w++) begin
            ctag[w] = TAG_BIT'($urandom);
            for (int k = 0; k < WPL; k++) cdata[w][k] = $urandom;
        end
    endtask

    initial begin
        bit hit7;
        rst = 1'b1;
        handler_req = 1'b0; handler_cached = 1'b0; handler_paddr = '0;
        handler_blkidx = '0; handler_wdata = '0; handler_wen = '0;
        fill_set(4'h0, 4'h0, 3'b000);

        repeat (3) step();
        check("rst_handler_fin", handler_fin, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mh_wen", mh_wen, 16'h0);
        check("rst_mh_meta_wen", mh_meta_wen, 4'h0);
        check("rst_handler_rdata", handler_rdata, 32'h0);
        check("rst_mh_blkidx", mh_blkidx, 4'h0);
        rst = 1'b0;
        step();

        // Cold miss into an empty set.
        rsp_mode = 0;
        fill_set(4'h0, 4'h0, 3'b000);
        run_txn("cold_miss", 1'b1, 32'h0000_1040, 4'h1, 32'h0, 4'h0);

        // Dirty PLRU victim way3 written back before refill.
        rsp_mode = 1; rsp_lat = 2;
        fill_set(4'hF, 4'b1000, 3'b000);
        ctag[3] = 22'h00002A;
        run_txn("writeback", 1'b1, 32'h0000_5280, 4'h5, 32'h0, 4'h0);

        // PLRU coverage with a clean, full set.
        rsp_mode = 2;
        fill_set(4'hF, 4'h0, 3'b000); run_txn("plru_000", 1'b1, 32'h0001_0000, 4'h2, 32'h0, 4'h0);
        fill_set(4'hF, 4'h0, 3'b100); run_txn("plru_100", 1'b1, 32'h0002_0040, 4'h3, 32'h0, 4'h0);
        fill_set(4'hF, 4'h0, 3'b001); run_txn("plru_001", 1'b1, 32'h0003_0080, 4'h4, 32'h0, 4'h0);
        fill_set(4'hF, 4'h0, 3'b011); run_txn("plru_011", 1'b1, 32'h0004_00C0, 4'h6, 32'h0, 4'h0);

        // Uncached read with 5-cycle latency, then uncached partial write.
        rsp_mode = 1; rsp_lat = 5;
        mem_over[32'h1FC0_0000] = 32'hDEAD_BEEF;
        run_txn("uc_read", 1'b0, 32'h1FC0_0000, 4'h0, 32'h0, 4'h0);
        run_txn("uc_write", 1'b0, 32'h1FC0_0104, 4'h0, 32'hCAFE_F00D, 4'b0011);

        // Address and data accepted in one cycle, with and without write-back.
        rsp_mode = 3;
        fill_set(4'hF, 4'hF, 3'b110); run_txn("same_cycle_wb", 1'b1, 32'h0123_4560, 4'h9, 32'h0, 4'h0);
        fill_set(4'b0111, 4'h0, 3'b000); run_txn("same_cycle", 1'b1, 32'h0ABC_0DC0, 4'hA, 32'h0, 4'h0);
        run_txn("same_cycle_uc", 1'b0, 32'h1FC0_0000, 4'h0, 32'h0, 4'h0);
        rsp_mode = 2;
        fill_set(4'h0, 4'h0, 3'b000); run_txn("zero_wait", 1'b1, 32'h0000_7FC0, 4'hF, 32'h0, 4'h0);

        // Reset in the middle of a refill, then a normal miss.
        rsp_mode = 0;
        fill_set(4'h0, 4'h0, 3'b000);
        start_txn(1'b1, 32'h0000_2000, 4'h7, 32'h0, 4'h0);
        hit7 = 1'b0;
        for (int c = 0; c < 2000 && !hit7; c++) begin
            step();
            if (arr_count % WPL == 7 && arr_q.size() == WPL - 7) hit7 = 1'b1;
        end
        check("mid_rst_word7_reached", hit7, 1'b1);
        rst = 1'b1;
        handler_req = 1'b0;
        step();
        check("mid_rst_handler_fin", handler_fin, 1'b1);
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_mh_wen", mh_wen, 16'h0);
        check("mid_rst_handler_rdata", handler_rdata, 32'h0);
        rst = 1'b0;
        last_rdata = 32'h0;
        mem_q.delete(); arr_q.delete(); meta_q.delete(); fin_q.delete();
        step();
        run_txn("after_rst", 1'b1, 32'h0000_2000, 4'h7, 32'h0, 4'h0);

        // Randomised mix of cached and uncached requests.
        for (int t = 0; t < 40; t++) begin
            rsp_mode = $urandom_range(0, 3);
            rsp_lat  = $urandom_range(1, 4);
            if ($urandom_range(0, 9) < 7) begin
                fill_set(($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom), 4'($urandom), 3'($urandom));
                run_txn("rand_cached", 1'b1, $urandom, 4'($urandom), 32'h0, 4'h0);
            end else begin
                run_txn("rand_uncached", 1'b0, $urandom, 4'($urandom), $urandom,
                        ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
